vga_draw_arbiter: RTL and testbench

- Shares the single VGA pixel-write port among N_REQ drawing units (player, walls, enemies, HUD).
- Each unit requests the port, receives an exclusive grant for one whole sprite draw, streams pixels, and releases the port on its last pixel.
- Requesters are served in round-robin order. The block replaces ad-hoc busy-OR gating in front of the VGA adapter.
- Outputs drive the adapter's x/y/colour/writeEn inputs directly.

---
 rtl/downwell_vga_pkg.sv | 16 +
 rtl/vga_draw_arbiter_rr_pick.sv | 37 +++
 rtl/vga_draw_arbiter.sv | 179 +++++++++++++++++
 tb/tb_vga_draw_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/downwell_vga_pkg.sv
// Screen geometry, colour constants and arbiter state shared by the VGA draw path.
package downwell_vga_pkg;

    localparam int unsigned X_W = 8;
    localparam int unsigned Y_W = 7;
    localparam int unsigned C_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

    localparam logic [C_W-1:0] BLACK = 3'b000;
    localparam logic [C_W-1:0] WHITE = 3'b111;

endpackage

// File: rtl/vga_draw_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping to 0.
module rr_pick
    import downwell_vga_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [PTR_W-1:0] idx_o
);

    logic found;

    // Upper pass covers [ptr, N_REQ-1]; the lower pass then wraps around from 0.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!found && req_i[i] && (32'(i) >= 32'(ptr_i))) begin
                found    = 1'b1;
                gnt_o[i] = 1'b1;
                idx_o    = PTR_W'(i);
            end
        end
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (!found && req_i[i]) begin
                found    = 1'b1;
                gnt_o[i] = 1'b1;
                idx_o    = PTR_W'(i);
            end
        end
    end

endmodule

// File: rtl/vga_draw_arbiter.sv
// Round-robin owner of the single VGA pixel-write port; one grant covers one whole sprite draw.
module vga_draw_arbiter #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned X_W        = downwell_vga_pkg::X_W,
    parameter int unsigned Y_W        = downwell_vga_pkg::Y_W,
    parameter int unsigned C_W        = downwell_vga_pkg::C_W,
    parameter int unsigned MAX_PIXELS = 64
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ-1:0]       pix_valid,
    input  logic [N_REQ-1:0]       pix_last,
    input  logic [N_REQ*X_W-1:0]   pix_x,
    input  logic [N_REQ*Y_W-1:0]   pix_y,
    input  logic [N_REQ*C_W-1:0]   pix_color,
    output logic [N_REQ-1:0]       gnt,
    output logic [X_W-1:0]         x_out,
    output logic [Y_W-1:0]         y_out,
    output logic [C_W-1:0]         color_out,
    output logic                   writeEn,
    output logic                   busy,
    output logic                   overrun
);

    import downwell_vga_pkg::arb_state_e;
    import downwell_vga_pkg::IDLE;
    import downwell_vga_pkg::OWN;
    import downwell_vga_pkg::BLACK;

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_PIXELS + 1);

    arb_state_e       state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [PTR_W-1:0] owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [X_W-1:0]   x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic [C_W-1:0]   c_q, c_d;
    logic             we_q, we_d;
    logic             busy_q, busy_d;
    logic             ovr_q, ovr_d;

    logic [N_REQ-1:0] pick_gnt_c;
    logic [PTR_W-1:0] pick_idx_c;
    logic             own_req_c;
    logic             own_valid_c;
    logic             own_last_c;
    logic [X_W-1:0]   own_x_c;
    logic [Y_W-1:0]   own_y_c;
    logic [C_W-1:0]   own_c_c;
    logic [PTR_W-1:0] next_ptr_c;
    logic             release_c;

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req_i (req),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt_c),
        .idx_o (pick_idx_c)
    );

    // Only the current owner's lane is visible to the FSM; other lanes never reach the port.
    always_comb begin
        own_req_c   = 1'b0;
        own_valid_c = 1'b0;
        own_last_c  = 1'b0;
        own_x_c     = '0;
        own_y_c     = '0;
        own_c_c     = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (owner_q == PTR_W'(i)) begin
                own_req_c   = req[i];
                own_valid_c = pix_valid[i];
                own_last_c  = pix_last[i];
                own_x_c     = pix_x[i*X_W +: X_W];
                own_y_c     = pix_y[i*Y_W +: Y_W];
                own_c_c     = pix_color[i*C_W +: C_W];
            end
        end
    end

    assign next_ptr_c = (owner_q == PTR_W'(N_REQ - 1)) ? '0 : owner_q + PTR_W'(1);

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        cnt_d     = cnt_q;
        gnt_d     = gnt_q;
        x_d       = x_q;
        y_d       = y_q;
        c_d       = c_q;
        we_d      = 1'b0;
        ovr_d     = 1'b0;
        release_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = OWN;
                    gnt_d   = pick_gnt_c;
                    owner_d = pick_idx_c;
                    cnt_d   = '0;
                end
            end
            OWN: begin
                if (own_valid_c) begin
                    we_d  = 1'b1;
                    x_d   = own_x_c;
                    y_d   = own_y_c;
                    c_d   = own_c_c;
                    cnt_d = cnt_q + CNT_W'(1);
                    // A pixel offered alongside a dropped req is still written before release.
                    if (own_last_c) begin
                        release_c = 1'b1;
                    end else if (cnt_d == CNT_W'(MAX_PIXELS)) begin
                        release_c = 1'b1;
                        ovr_d     = 1'b1;
                    end else if (!own_req_c) begin
                        release_c = 1'b1;
                    end
                end else if (!own_req_c) begin
                    release_c = 1'b1;
                end
                if (release_c) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    ptr_d   = next_ptr_c;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
        busy_d = (state_d == OWN);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            c_q     <= C_W'(BLACK);
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            c_q     <= c_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            ovr_q   <= ovr_d;
        end
    end

    assign gnt       = gnt_q;
    assign x_out     = x_q;
    assign y_out     = y_q;
    assign color_out = c_q;
    assign writeEn   = we_q;
    assign busy      = busy_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Scoreboard bench for vga_draw_arbiter: stimulus queues expected writes and grants, a negedge monitor checks them.
module tb_vga_draw_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic [3:0]  req, pix_valid, pix_last;
    logic [31:0] pix_x;
    logic [27:0] pix_y;
    logic [11:0] pix_color;
    logic [3:0]  gnt;
    logic [7:0]  x_out;
    logic [6:0]  y_out;
    logic [2:0]  color_out;
    logic        writeEn, busy, overrun;

    vga_draw_arbiter dut (
        .clk       (clk),
        .resetn    (resetn),
        .req       (req),
        .pix_valid (pix_valid),
        .pix_last  (pix_last),
        .pix_x     (pix_x),
        .pix_y     (pix_y),
        .pix_color (pix_color),
        .gnt       (gnt),
        .x_out     (x_out),
        .y_out     (y_out),
        .color_out (color_out),
        .writeEn   (writeEn),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        logic       ovr;
    } exp_t;

    exp_t exp_q[$];
    int   exp_g[$];

    // Written only by the monitor.
    int   checks = 0;
    int   fails  = 0;
    int   zero_done = 0;
    int   to_seen = 0;
    bit   mon_done = 1'b0;
    logic [3:0] prev_gnt = '0;

    // Written only by the stimulus.
    int   zero_req = 0;
    int   to_cnt = 0;
    bit   end_req = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        int   gi;
        logic [3:0] gexp;
        if (writeEn) begin
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: got x=%0d y=%0d c=%0d ovr=%0b, required no write", x_out, y_out, color_out, overrun);
            end else begin
                e = exp_q.pop_front();
                if (x_out !== e.x || y_out !== e.y || color_out !== e.c || overrun !== e.ovr) begin
                    fails++;
                    $display("FAIL pixel_write: got x=%0d y=%0d c=%0d ovr=%0b, required x=%0d y=%0d c=%0d ovr=%0b",
                             x_out, y_out, color_out, overrun, e.x, e.y, e.c, e.ovr);
                end
            end
        end else if (overrun) begin
            checks++;
            fails++;
            $display("FAIL overrun_no_write: got overrun=1 writeEn=0, required overrun only with a write");
        end
        if (gnt !== 4'b0000 && prev_gnt === 4'b0000) begin
            checks++;
            if (exp_g.size() == 0) begin
                fails++;
                $display("FAIL unexpected_grant: got gnt=%b, required none", gnt);
            end else begin
                gi   = exp_g.pop_front();
                gexp = 4'b0001 << gi;
                if (gnt !== gexp) begin
                    fails++;
                    $display("FAIL grant_order: got gnt=%b, required %b", gnt, gexp);
                end
            end
        end
        if (gnt !== 4'b0000 && prev_gnt !== 4'b0000) begin
            checks++;
            if (gnt !== prev_gnt) begin
                fails++;
                $display("FAIL grant_gap: got gnt=%b right after %b, required an idle cycle", gnt, prev_gnt);
            end
        end
        checks++;
        if (!$onehot0(gnt) || busy !== (gnt !== 4'b0000)) begin
            fails++;
            $display("FAIL busy_gnt: got gnt=%b busy=%0b, required one-hot gnt with busy=|gnt", gnt, busy);
        end
        if (zero_req != zero_done) begin
            zero_done++;
            checks++;
            if (gnt !== 4'b0 || x_out !== 8'd0 || y_out !== 7'd0 || color_out !== 3'd0 ||
                writeEn !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
                fails++;
                $display("FAIL reset_state: got gnt=%b x=%0d y=%0d c=%0d we=%0b busy=%0b ovr=%0b, required all 0",
                         gnt, x_out, y_out, color_out, writeEn, busy, overrun);
            end
        end
        if (to_cnt != to_seen) begin
            to_seen++;
            checks++;
            fails++;
            $display("FAIL grant_timeout: got no grant within budget, required grant");
        end
        if (end_req && !mon_done) begin
            checks++;
            if (exp_q.size() != 0 || exp_g.size() != 0) begin
                fails++;
                $display("FAIL leftover: got %0d writes and %0d grants outstanding, required 0 and 0", exp_q.size(), exp_g.size());
            end
            mon_done = 1'b1;
        end
        prev_gnt = gnt;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_pix();
        pix_valid = '0;
        pix_last  = '0;
    endtask

    task automatic wait_gnt(input int r);
        int n = 0;
        idle_pix();
        while (gnt[r] !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (gnt[r] !== 1'b1) to_cnt++;
    endtask

    // One pixel on lane r for one cycle; junk lights every other lane with x=99 and pix_last.
    task automatic drive_pix(input int r, input logic [7:0] x, input logic [6:0] y, input logic [2:0] c,
                             input logic last, input logic push, input logic ovr, input logic junk);
        exp_t e;
        pix_valid = junk ? 4'b1111 : 4'b0000;
        pix_last  = junk ? 4'b1111 : 4'b0000;
        pix_x     = {4{8'd99}};
        pix_y     = {4{7'd99}};
        pix_color = {4{3'd5}};
        pix_valid[r] = 1'b1;
        pix_last[r]  = last;
        pix_x[r*8 +: 8]     = x;
        pix_y[r*7 +: 7]     = y;
        pix_color[r*3 +: 3] = c;
        if (push) begin
            e.x = x; e.y = y; e.c = c; e.ovr = ovr;
            exp_q.push_back(e);
        end
        tick();
    endtask

    initial begin
        int n;
        resetn = 1'b0;
        req = '0; pix_valid = '0; pix_last = '0;
        pix_x = '0; pix_y = '0; pix_color = '0;
        tick();
        tick();
        zero_req++;
        resetn = 1'b1;

        // Contention: all requesters held, 3-pixel draws, order 0,1,2,3,0.
        exp_g.push_back(0); exp_g.push_back(1); exp_g.push_back(2);
        exp_g.push_back(3); exp_g.push_back(0);
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_gnt(g % 4);
            for (int p = 1; p <= 3; p++) begin
                if (g == 4 && p == 3) req = 4'b0000;
                drive_pix(g % 4, 8'(16 * g + p), 7'(4 * (g % 4) + p), 3'(p + g), (p == 3), 1'b1, 1'b0, 1'b1);
            end
        end

        // Single requester 1, twelve pixels, release on the last.
        idle_pix();
        tick();
        exp_g.push_back(1);
        req = 4'b0010;
        wait_gnt(1);
        for (int p = 1; p <= 12; p++) begin
            if (p == 12) req = 4'b0000;
            drive_pix(1, 8'(20 + p), 7'(40 + p), 3'(p), (p == 12), 1'b1, 1'b0, 1'b0);
        end

        // Overrun: ptr=2 so lane 2 wins over lane 0; 70 pixels, only 64 written.
        idle_pix();
        tick();
        exp_g.push_back(2);
        req = 4'b0101;
        wait_gnt(2);
        for (int p = 1; p <= 70; p++) begin
            if (p == 65) begin
                req = 4'b0011;
                exp_g.push_back(0);
            end
            drive_pix(2, 8'(p), 7'(p), 3'(p), 1'b0, (p <= 64), (p == 64), 1'b0);
        end

        // Abort: owner 0 drops req after 5 pixels; requester 1 is next.
        wait_gnt(0);
        exp_g.push_back(1);
        for (int p = 1; p <= 5; p++)
            drive_pix(0, 8'(200 + p), 7'(100 + p), 3'(7 - p), 1'b0, 1'b1, 1'b0, 1'b0);
        idle_pix();
        req = 4'b0010;
        tick();

        // Non-owner strobes: lane 0 pulses x=99 while owner 1 draws.
        wait_gnt(1);
        for (int p = 1; p <= 4; p++) begin
            if (p == 4) req = 4'b0000;
            drive_pix(1, 8'(60 + p), 7'(10 + p), downwell_vga_pkg::WHITE, (p == 4), 1'b1, 1'b0, (p % 2 == 0));
        end

        // Reset mid-draw during pixel 7 of owner 3, then regrant owner 3.
        idle_pix();
        tick();
        exp_g.push_back(3);
        req = 4'b1000;
        wait_gnt(3);
        for (int p = 1; p <= 6; p++)
            drive_pix(3, 8'(120 + p), 7'(70 + p), 3'(p), 1'b0, 1'b1, 1'b0, 1'b0);
        resetn = 1'b0;
        drive_pix(3, 8'd127, 7'd77, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        zero_req++;
        resetn = 1'b1;
        idle_pix();
        exp_g.push_back(3);
        wait_gnt(3);
        for (int p = 1; p <= 2; p++) begin
            if (p == 2) req = 4'b0000;
            drive_pix(3, 8'(130 + p), 7'(80 + p), downwell_vga_pkg::BLACK, (p == 2), 1'b1, 1'b0, 1'b0);
        end

        idle_pix();
        repeat (4) tick();
        end_req = 1'b1;
        n = 0;
        while (!mon_done && n < 20) begin
            tick();
            n++;
        end
        if (!mon_done) begin
            $display("FAIL monitor_done: got no final check, required one");
            $fatal(1);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
